// File: rtl/riscv_core_immpack.sv
// Immediate packer: scatters a 64-bit immediate into an RV32 instruction word
// (I/S/B/J/U formats), range-checks it, and buffers {instr, err} in an in-order FIFO.
// Optional feature: define IMMPACK_ERRCNT_EN to add the saturating o_immpack_errcnt port.
module riscv_core_immpack #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        i_immpack_clk,
  input  logic        i_immpack_rst,
  input  logic        i_immpack_valid,
  output logic        o_immpack_ready,
  input  logic [63:0] i_immpack_imm,
  input  logic [2:0]  i_immpack_immsrc,
  input  logic [31:0] i_immpack_base,
  output logic        o_immpack_valid,
  input  logic        i_immpack_out_ready,
  output logic [31:0] o_immpack_instr,
  output logic        o_immpack_err
`ifdef IMMPACK_ERRCNT_EN
  ,
  output logic [7:0]  o_immpack_errcnt
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [2:0] {
    SrcI = 3'b000,
    SrcS = 3'b001,
    SrcB = 3'b010,
    SrcJ = 3'b011,
    SrcU = 3'b100
  } immsrc_e;

  logic [31:0]     enc_instr;
  logic            enc_err;
  logic [31:0]     mem_instr_q [DEPTH];
  logic            mem_err_q   [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [31:0]     last_instr_q;
  logic            last_err_q;
  logic            push, pop;

  assign o_immpack_ready = (count_q < DepthCnt);
  assign o_immpack_valid = (count_q != '0);
  assign push = i_immpack_valid && o_immpack_ready;
  assign pop  = o_immpack_valid && i_immpack_out_ready;

  // Encode and range-check the incoming immediate; base bits outside the field pass through.
  always_comb begin
    enc_instr = i_immpack_base;
    enc_err   = 1'b1;
    unique case (i_immpack_immsrc)
      SrcI: begin
        enc_instr = {i_immpack_imm[11:0], i_immpack_base[19:0]};
        enc_err   = !((&i_immpack_imm[63:11]) || !(|i_immpack_imm[63:11]));
      end
      SrcS: begin
        enc_instr = {i_immpack_imm[11:5], i_immpack_base[24:12], i_immpack_imm[4:0],
                     i_immpack_base[6:0]};
        enc_err   = !((&i_immpack_imm[63:11]) || !(|i_immpack_imm[63:11]));
      end
      SrcB: begin
        enc_instr = {i_immpack_imm[12], i_immpack_imm[10:5], i_immpack_base[24:12],
                     i_immpack_imm[4:1], i_immpack_imm[11], i_immpack_base[6:0]};
        enc_err   = !((&i_immpack_imm[63:12]) || !(|i_immpack_imm[63:12])) ||
                    i_immpack_imm[0];
      end
      SrcJ: begin
        enc_instr = {i_immpack_imm[20], i_immpack_imm[10:1], i_immpack_imm[11],
                     i_immpack_imm[19:12], i_immpack_base[11:0]};
        enc_err   = !((&i_immpack_imm[63:20]) || !(|i_immpack_imm[63:20])) ||
                    i_immpack_imm[0];
      end
      SrcU: begin
        enc_instr = {i_immpack_imm[31:12], i_immpack_base[11:0]};
        enc_err   = !((&i_immpack_imm[63:31]) || !(|i_immpack_imm[63:31])) ||
                    (|i_immpack_imm[11:0]);
      end
      default: begin
        enc_instr = i_immpack_base;
        enc_err   = 1'b1;
      end
    endcase
  end

  // FIFO storage, pointers and occupancy; reset flushes everything asynchronously.
  always_ff @(posedge i_immpack_clk or posedge i_immpack_rst) begin
    if (i_immpack_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr_q[i] <= '0;
        mem_err_q[i]   <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_instr_q[wr_ptr_q] <= enc_instr;
        mem_err_q[wr_ptr_q]   <= enc_err;
        wr_ptr_q              <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Remember the last popped word so the outputs hold it while the FIFO is empty.
  always_ff @(posedge i_immpack_clk or posedge i_immpack_rst) begin
    if (i_immpack_rst) begin
      last_instr_q <= '0;
      last_err_q   <= 1'b0;
    end else if (pop) begin
      last_instr_q <= mem_instr_q[rd_ptr_q];
      last_err_q   <= mem_err_q[rd_ptr_q];
    end
  end

  assign o_immpack_instr = o_immpack_valid ? mem_instr_q[rd_ptr_q] : last_instr_q;
  assign o_immpack_err   = o_immpack_valid ? mem_err_q[rd_ptr_q]   : last_err_q;

`ifdef IMMPACK_ERRCNT_EN
  logic [7:0] errcnt_q;

  // Count erroneous requests at accept time, saturating at 255.
  always_ff @(posedge i_immpack_clk or posedge i_immpack_rst) begin
    if (i_immpack_rst) begin
      errcnt_q <= '0;
    end else if (push && enc_err && (errcnt_q != 8'hFF)) begin
      errcnt_q <= errcnt_q + 8'd1;
    end
  end

  assign o_immpack_errcnt = errcnt_q;
`endif

endmodule

// File: tb/tb_riscv_core_immpack.sv
// Directed bench for riscv_core_immpack (DEPTH=2); checks encoding, range errors,
// FIFO backpressure/order, empty hold and asynchronous reset. Honours IMMPACK_ERRCNT_EN.
module tb_riscv_core_immpack;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] imm;
  logic [2:0]  immsrc;
  logic [31:0] base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;
`ifdef IMMPACK_ERRCNT_EN
  logic [7:0]  errcnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  riscv_core_immpack #(.DEPTH(2)) dut (
    .i_immpack_clk       (clk),
    .i_immpack_rst       (rst),
    .i_immpack_valid     (in_valid),
    .o_immpack_ready     (in_ready),
    .i_immpack_imm       (imm),
    .i_immpack_immsrc    (immsrc),
    .i_immpack_base      (base),
    .o_immpack_valid     (out_valid),
    .i_immpack_out_ready (out_ready),
    .o_immpack_instr     (instr),
    .o_immpack_err       (err)
`ifdef IMMPACK_ERRCNT_EN
    ,
    .o_immpack_errcnt    (errcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request and hold it until accepted (bounded wait).
  task automatic push(input logic [63:0] i, input logic [2:0] s, input logic [31:0] b);
    int n = 0;
    imm = i; immsrc = s; base = b; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("push_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for a head word, compare it, then pop it.
  task automatic pop_check(input string tag, input logic [31:0] ei, input logic ee);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_instr"}, 64'(instr), 64'(ei));
    check({tag, "_err"}, 64'(err), 64'(ee));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    imm = '0; immsrc = '0; base = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // I, imm=-1: visible one cycle after accept
    push(64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 32'h0000_0013);
    check("i_latency", 64'(out_valid), 64'd1);
    pop_check("i_neg1", 32'hFFF0_0013, 1'b0);
    check("empty_valid", 64'(out_valid), 64'd0);
    check("hold_instr", 64'(instr), 64'hFFF0_0013);

    push(64'h800, 3'b010, 32'h0000_0063);
    pop_check("b_800", 32'h0000_00E3, 1'b0);
    push(64'd3, 3'b011, 32'h0000_006F);
    pop_check("j_odd", 32'h0020_006F, 1'b1);
    push(64'h800, 3'b000, 32'h0000_0013);
    pop_check("i_range", 32'h8000_0013, 1'b1);
    push(64'd0, 3'b101, 32'hDEAD_BEEF);
    pop_check("illegal", 32'hDEAD_BEEF, 1'b1);
    push(64'h1234_5000, 3'b100, 32'h0000_0037);
    pop_check("u_ok", 32'h1234_5037, 1'b0);
    push(64'h1234_5001, 3'b100, 32'h0000_0037);
    pop_check("u_low", 32'h1234_5037, 1'b1);
    push(64'hFFFF_FFFF_FFFF_FFFC, 3'b001, 32'h0000_2023);
    pop_check("s_neg4", 32'hFE00_2E23, 1'b0);
    check("hold_err", 64'(err), 64'd0);
`ifdef IMMPACK_ERRCNT_EN
    check("errcnt4", 64'(errcnt), 64'd4);
`endif

    // Backpressure: fill, offer an extra request, then drain in order
    push(64'd1, 3'b000, 32'h0000_0013);
    push(64'd2, 3'b000, 32'h0000_0013);
    check("full_ready", 64'(in_ready), 64'd0);
    imm = 64'd5; immsrc = 3'b000; base = 32'h0000_0013; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    pop_check("bp0", 32'h0010_0013, 1'b0);
    pop_check("bp1", 32'h0020_0013, 1'b0);
    check("drain_ready", 64'(in_ready), 64'd1);
    check("drain_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset with two entries buffered
    push(64'h800, 3'b000, 32'h0000_0013);
    push(64'd7, 3'b000, 32'h0000_0013);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd1);
    check("arst_instr", 64'(instr), 64'd0);
`ifdef IMMPACK_ERRCNT_EN
    check("arst_errcnt", 64'(errcnt), 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", 64'(out_valid), 64'd0);
    push(64'h0ABC_D000, 3'b100, 32'h0000_00B7);
    pop_check("post_rst_u", 32'h0ABC_D0B7, 1'b0);
    check("post_rst_empty", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
